// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: operand widths, MEM-stage opcodes,
// arbiter FSM states and the payload latched onto the external bus.
// Types only, no logic, no latency, no backpressure.
package mem_bus_arbiter_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2,
    MEM_OP_RSVD  = 2'd3
  } mem_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUS_IF = 2'd1,
    ARB_BUS_DM = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  // Payload held on bus_* for the whole transfer.
  typedef struct packed {
    u32_t   addr;
    u32_t   wdata;
    wrstb_t wrstb;
    logic   we;
  } arb_req_t;

endpackage

// File: rtl/mem_bus_timer.sv
// Per-transfer watchdog: counts active bus cycles and flags the last allowed one.
// Latency: expired is combinational from the count, high in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; clear has priority over counting.
// Ports: clk, rst (sync, active-high), clear (restart at grant), en (bus cycle active),
//        expired (this cycle is the final one before abort).
module mem_bus_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  // cnt holds the number of completed bus cycles, so the cycle in which it
  // equals TIMEOUT_CYCLES-1 is the last one the slave is allowed.
  assign expired = en && (cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch (read-only) and the MEM stage.
// Latency: grant on the edge a request is seen in IDLE; ack one cycle after bus_ack or timeout.
// Backpressure: requests are level-held until their one-cycle ack; DM wins, IF may starve.
// Optional feature macro: STARVE_GUARD_EN (after MAX_DM_STREAK DM grants that passed over
// a waiting IF, the next grant goes to IF).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 IF read request, held until if_ack
//   if_ack/if_rdata/if_err         IF completion pulse, data, timeout flag
//   dm_req/dm_op/dm_addr/dm_wdata/dm_wrstb   MEM-stage request and payload
//   dm_ack/dm_rdata/dm_err         MEM-stage completion pulse, load data, timeout flag
//   bus_cyc/bus_we/bus_addr/bus_wdata/bus_wrstb   registered bus master outputs
//   bus_ack/bus_rdata              slave completion and read data
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_DM_STREAK  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  mem_op_t     dm_op,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  wrstb_t      dm_wrstb,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wrstb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  if (TIMEOUT_CYCLES < 1 || MAX_DM_STREAK < 1) begin : g_param_check
    $error("mem_bus_arbiter: TIMEOUT_CYCLES and MAX_DM_STREAK must be >= 1");
  end

  arb_state_t state;
  arb_req_t   req_q;
  logic       dm_pending;
  logic       dm_is_store;
  logic       in_bus;
  logic       done;
  logic       tmr_expired;
  logic       grant_dm;
  logic       grant_if;

  assign dm_pending  = dm_req && (dm_op != MEM_OP_NONE);
  assign dm_is_store = (dm_op == MEM_OP_STORE);
  assign in_bus      = (state == ARB_BUS_IF) || (state == ARB_BUS_DM);
  // A slave ack in the expiry cycle still counts as a normal completion.
  assign done        = in_bus && (bus_ack || tmr_expired);

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  logic [SW-1:0] streak;
  logic          starve;

  // streak counts DM grants that passed over a waiting IF; it never exceeds
  // MAX_DM_STREAK because reaching it forces the next grant to IF.
  assign starve   = if_req && (streak >= SW'(MAX_DM_STREAK));
  assign grant_dm = (state == ARB_IDLE) && dm_pending && !starve;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_dm) begin
      streak <= if_req ? streak + 1'b1 : '0;
    end
  end
`else
  assign grant_dm = (state == ARB_IDLE) && dm_pending;
`endif

  assign grant_if = (state == ARB_IDLE) && if_req && !grant_dm;

  mem_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_dm || grant_if),
    .en     (in_bus),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      req_q    <= '0;
      bus_cyc  <= 1'b0;
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      dm_ack   <= 1'b0;
      dm_err   <= 1'b0;
      dm_rdata <= '0;
    end else begin
      // Response outputs are single-cycle pulses; data is zero outside the ack cycle.
      if_ack   <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      dm_ack   <= 1'b0;
      dm_err   <= 1'b0;
      dm_rdata <= '0;
      case (state)
        ARB_IDLE: begin
          if (grant_dm) begin
            req_q <= '{addr:  dm_addr,
                       wdata: dm_is_store ? dm_wdata : '0,
                       wrstb: dm_is_store ? dm_wrstb : '0,
                       we:    dm_is_store};
            bus_cyc <= 1'b1;
            state   <= ARB_BUS_DM;
          end else if (grant_if) begin
            req_q   <= '{addr: if_addr, wdata: '0, wrstb: '0, we: 1'b0};
            bus_cyc <= 1'b1;
            state   <= ARB_BUS_IF;
          end
        end
        ARB_BUS_IF, ARB_BUS_DM: begin
          if (done) begin
            bus_cyc <= 1'b0;
            req_q   <= '0;
            state   <= ARB_RESP;
            if (state == ARB_BUS_IF) begin
              if_ack   <= 1'b1;
              if_err   <= !bus_ack;
              if_rdata <= bus_ack ? bus_rdata : '0;
            end else begin
              dm_ack   <= 1'b1;
              dm_err   <= !bus_ack;
              dm_rdata <= (bus_ack && !req_q.we) ? bus_rdata : '0;
            end
          end
        end
        // One dead cycle so a request still high during its ack is not regranted.
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.wdata;
  assign bus_wrstb = req_q.wrstb;

endmodule
